fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Parametrised decoupling queue between the fetch and decode stages. It supersedes the single fixed Fetch-to-Decode register, which only offers stall and flush.
- Buffers up to DEPTH {instr, pc} pairs.
- Uses valid/ready handshakes on both sides.
- Flushes all entries in one cycle on a control change.
- Reports occupancy, so fetch can keep running ahead while decode stalls.

Parameters:
XLEN, 32, width of the instr and pc fields
DEPTH, 4, number of entries; a power of two, at least 2
AFULL_LVL, DEPTH-1, occupancy at or above which almost_full asserts; range 1..DEPTH

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
flush  input  1  synchronous flush of every entry (pc_srcE | jumpE)
enq_valid  input  1  fetch presents an entry
enq_ready  output  1  queue can accept an entry
enq_instr  input  XLEN  fetched instruction
enq_pc  input  XLEN  pc of the fetched instruction
deq_valid  output  1  head entry is valid
deq_ready  input  1  decode consumes the head (i.e. not stallD)
deq_instr  output  XLEN  head instruction
deq_pc  output  XLEN  head pc
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
almost_full  output  1  count >= AFULL_LVL

Behaviour:
- Storage: circular buffer with DEPTH entries.
  - Read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty = (rd_ptr == wr_ptr).
  - full = index bits equal and wrap bits differ.
  - Pointers wrap naturally modulo 2*DEPTH with no special case.
- Reset (reset=0, asynchronous): pointers = 0, count = 0, deq_valid = 0, enq_ready = 1, almost_full = 0.
  - deq_instr = 32'h00000013 (NOP).
  - deq_pc = 0.
  - Storage contents are not reset.
  - Assertion mid-operation discards every entry immediately.
- Enqueue fires when enq_valid & enq_ready on a rising edge.
  - The entry is written at wr_ptr, then wr_ptr increments.
- Dequeue fires when deq_valid & deq_ready.
  - rd_ptr increments.
- enq_ready = !full.
  - It is registered-state only and never depends combinationally on deq_ready.
  - When full, an enqueue is refused even if a dequeue happens in the same cycle.
- deq_valid = !empty. deq_instr/deq_pc are driven from the head entry.
  - When empty, deq_instr = NOP and deq_pc = 0.
- Latency: an entry enqueued at edge N is visible at deq at edge N+1. Minimum latency is 1 cycle.
- Simultaneous enqueue and dequeue (not full, not empty): both fire and count is unchanged.
- Flush has priority over everything else:
  - At the edge with flush=1, rd_ptr = wr_ptr = 0 and count = 0.
  - Any same-cycle enqueue is dropped.
  - Any same-cycle dequeue handshake still counts as consumed by decode.
  - On the cycle after the flush, deq_valid = 0 and enq_ready = 1.
- Dequeuing when empty or enqueuing when full is impossible by construction. Data is never overwritten or duplicated.
- count update: count_next = count + enq_fire - deq_fire, or 0 on flush. count is always in 0..DEPTH.
- almost_full is derived combinationally from the count register, so it has no path from the enq/deq inputs.

Optional Feature:
FETCH_QUEUE_BYPASS_EN
- Defined: when the queue is empty, enq_valid=1, flush=0, the enqueue passes straight through.
  - deq_valid = enq_valid combinationally.
  - deq_instr/deq_pc = enq_instr/enq_pc.
  - If deq_ready=1 the entry is consumed that same cycle and nothing is written; zero latency.
  - If deq_ready=0 the entry is written normally.
  - enq_ready stays purely registered.
- Undefined: no combinational path from enq to deq. Minimum latency is 1 cycle, as described in Behaviour.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs -> deq_valid=0, count=0, enq_ready=1, deq_instr=32'h00000013, deq_pc=0.
- Fill and drain, DEPTH=4: enqueue pcs 0x0,0x4,0x8,0xC with deq_ready=0 -> count reaches 4, enq_ready=0, almost_full=1 from count=3. Then deq_ready=1 -> pcs 0x0,0x4,0x8,0xC emerge in order, one per cycle, and count returns to 0.
- Wrap-around: stream 20 entries (pc=4*i) with enq_valid=1 and deq_ready toggling 1,0,1,0 -> all 20 pcs emerge in order, none lost or duplicated, count never exceeds 4.
- Full with same-cycle dequeue: full queue, enq_valid=1, deq_ready=1 -> one dequeue, no enqueue, count=3 on the next cycle, enq_ready=1.
- Flush: 3 entries queued, flush=1 with enq_valid=1 (pc=0x100) -> on the next cycle count=0, deq_valid=0, and pc 0x100 never appears at deq.
- Bypass with FETCH_QUEUE_BYPASS_EN: empty queue, enq_valid=1 (pc=0x40), deq_ready=1 -> deq_valid=1 and deq_pc=0x40 in the same cycle, count stays 0. Without the macro, deq_pc=0x40 appears one cycle later.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode decoupling queue with valid/ready handshakes and one-cycle flush
// Optional zero-latency pass-through when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [XLEN-1:0]          enq_instr,
    input  logic [XLEN-1:0]          enq_pc,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [XLEN-1:0]          deq_instr,
    output logic [XLEN-1:0]          deq_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [XLEN-1:0] NOP   = XLEN'(32'h0000_0013);
    localparam logic [AW:0]     AFULL = (AW+1)'(AFULL_LVL);
    localparam logic [AW:0]     ONE   = (AW+1)'(1);

    logic [XLEN-1:0] instrMem [DEPTH];
    logic [XLEN-1:0] pcMem    [DEPTH];

    logic [AW:0] rdPtr;
    logic [AW:0] wrPtr;
    logic [AW:0] countQ;
    logic        empty;
    logic        full;
    logic        enqFire;
    logic        deqFire;
    logic        bypass;
    logic        bypassOut;
    logic        doWrite;
    logic        doRead;

    assign empty     = (rdPtr == wrPtr);
    assign full      = (rdPtr[AW-1:0] == wrPtr[AW-1:0]) && (rdPtr[AW] != wrPtr[AW]);
    assign enq_ready = !full;
    assign enqFire   = enq_valid & enq_ready;
    assign deqFire   = deq_valid & deq_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass    = empty & enq_valid & !flush;
    // Output-side copy is held off while reset is asserted so deq stays quiet during reset.
    assign bypassOut = bypass & reset;
`else
    assign bypass    = 1'b0;
    assign bypassOut = 1'b0;
`endif

    always_comb begin
        deq_valid = !empty;
        deq_instr = instrMem[rdPtr[AW-1:0]];
        deq_pc    = pcMem[rdPtr[AW-1:0]];
        if (bypassOut) begin
            deq_valid = 1'b1;
            deq_instr = enq_instr;
            deq_pc    = enq_pc;
        end else if (empty) begin
            deq_instr = NOP;
            deq_pc    = '0;
        end
    end

    // A bypassed entry consumed this cycle never touches storage or pointers.
    assign doWrite = enqFire & !flush & !(bypass & deq_ready);
    assign doRead  = deqFire & !flush & !bypass;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr  <= '0;
            wrPtr  <= '0;
            countQ <= '0;
        end else if (flush) begin
            rdPtr  <= '0;
            wrPtr  <= '0;
            countQ <= '0;
        end else begin
            if (doWrite) wrPtr <= wrPtr + ONE;
            if (doRead)  rdPtr <= rdPtr + ONE;
            case ({doWrite, doRead})
                2'b10:   countQ <= countQ + ONE;
                2'b01:   countQ <= countQ - ONE;
                default: countQ <= countQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doWrite) begin
            instrMem[wrPtr[AW-1:0]] <= enq_instr;
            pcMem[wrPtr[AW-1:0]]    <= enq_pc;
        end
    end

    assign count       = countQ;
    assign almost_full = (countQ >= AFULL);

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue against a queue-based reference model
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AFULL = DEPTH - 1;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [31:0] enq_instr = '0;
    logic [31:0] enq_pc = '0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc;
    logic [2:0]  count;
    logic        almost_full;

    int nVec = 0;
    int nErr = 0;
    logic [63:0] q[$];

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_instr(enq_instr), .enq_pc(enq_pc),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_instr(deq_instr), .deq_pc(deq_pc),
        .count(count), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    function automatic bit bypNow();
        return BYP && reset && q.size() == 0 && enq_valid && !flush;
    endfunction

    function automatic bit expValid();
        return q.size() > 0 || bypNow();
    endfunction

    function automatic logic [31:0] expPc();
        if (q.size() > 0) return q[0][31:0];
        if (bypNow()) return enq_pc;
        return 32'h0;
    endfunction

    function automatic logic [31:0] expInstr();
        if (q.size() > 0) return q[0][63:32];
        if (bypNow()) return enq_instr;
        return NOP;
    endfunction

    // Advance one clock edge and apply the queue rules to the reference model.
    task automatic tick();
        bit byp, enqF, deqF;
        int sz;
        sz   = q.size();
        byp  = bypNow();
        enqF = enq_valid && sz < DEPTH;
        deqF = deq_ready && sz > 0;
        @(posedge clk);
        if (!reset || flush) q.delete();
        else if (!(byp && deq_ready)) begin
            if (deqF) void'(q.pop_front());
            if (enqF) q.push_back({enq_instr, enq_pc});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) begin
            enq_valid = 1'($urandom); deq_ready = 1'($urandom); flush = 1'($urandom);
            enq_pc = $urandom; enq_instr = $urandom;
            #1;
            nVec++; if (deq_valid !== 1'b0) begin nErr++; $display("FAIL reset_deq_valid got %b exp 0", deq_valid); end
            nVec++; if (count !== 3'd0) begin nErr++; $display("FAIL reset_count got %0d exp 0", count); end
            nVec++; if (enq_ready !== 1'b1) begin nErr++; $display("FAIL reset_enq_ready got %b exp 1", enq_ready); end
            nVec++; if (deq_instr !== NOP) begin nErr++; $display("FAIL reset_deq_instr got %h exp %h", deq_instr, NOP); end
            nVec++; if (deq_pc !== 32'h0) begin nErr++; $display("FAIL reset_deq_pc got %h exp 0", deq_pc); end
            nVec++; if (almost_full !== 1'b0) begin nErr++; $display("FAIL reset_almost_full got %b exp 0", almost_full); end
            @(posedge clk); @(negedge clk);
        end
        idle();
        reset = 1'b1;
        q.delete();
    endtask

    task automatic test_fill_drain();
        idle();
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1'b1; enq_pc = 32'(4 * i); enq_instr = $urandom;
            #1;
            nVec++; if (count !== 3'(i)) begin nErr++; $display("FAIL fill_count got %0d exp %0d", count, i); end
            nVec++; if (almost_full !== (i >= AFULL)) begin nErr++; $display("FAIL fill_afull got %b exp %b", almost_full, i >= AFULL); end
            nVec++; if (enq_ready !== 1'b1) begin nErr++; $display("FAIL fill_enq_ready got %b exp 1", enq_ready); end
            tick();
        end
        enq_valid = 1'b0;
        #1;
        nVec++; if (count !== 3'd4) begin nErr++; $display("FAIL full_count got %0d exp 4", count); end
        nVec++; if (enq_ready !== 1'b0) begin nErr++; $display("FAIL full_enq_ready got %b exp 0", enq_ready); end
        nVec++; if (almost_full !== 1'b1) begin nErr++; $display("FAIL full_afull got %b exp 1", almost_full); end
        for (int i = 0; i < 4; i++) begin
            deq_ready = 1'b1;
            #1;
            nVec++; if (deq_valid !== 1'b1) begin nErr++; $display("FAIL drain_valid got %b exp 1", deq_valid); end
            nVec++; if (deq_pc !== 32'(4 * i)) begin nErr++; $display("FAIL drain_pc got %h exp %h", deq_pc, 4 * i); end
            tick();
        end
        idle();
        #1;
        nVec++; if (count !== 3'd0) begin nErr++; $display("FAIL drained_count got %0d exp 0", count); end
        nVec++; if (deq_valid !== 1'b0) begin nErr++; $display("FAIL drained_valid got %b exp 0", deq_valid); end
    endtask

    task automatic test_wrap();
        int sent = 0, recv = 0, cyc = 0;
        while (recv < 20 && cyc < 200) begin
            enq_valid = (sent < 20); enq_pc = 32'(4 * sent); enq_instr = $urandom;
            deq_ready = (cyc % 2 == 0);
            #1;
            nVec++; if (count !== 3'(q.size()) || count > 3'd4) begin nErr++; $display("FAIL wrap_count got %0d exp %0d", count, q.size()); end
            nVec++; if (deq_valid !== expValid()) begin nErr++; $display("FAIL wrap_valid got %b exp %b", deq_valid, expValid()); end
            if (deq_valid && deq_ready) begin
                nVec++; if (deq_pc !== 32'(4 * recv)) begin nErr++; $display("FAIL wrap_order got %h exp %h", deq_pc, 4 * recv); end
                recv++;
            end
            if (enq_valid && q.size() < DEPTH) sent++;
            tick();
            cyc++;
        end
        idle();
        nVec++; if (recv != 20) begin nErr++; $display("FAIL wrap_received got %0d exp 20", recv); end
        #1;
        nVec++; if (deq_valid !== 1'b0) begin nErr++; $display("FAIL wrap_extra got %b exp 0", deq_valid); end
    endtask

    task automatic test_full_same_cycle();
        idle();
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1'b1; enq_pc = 32'h1000 + 32'(4 * i); enq_instr = $urandom;
            tick();
        end
        enq_valid = 1'b1; enq_pc = 32'h2000; deq_ready = 1'b1;
        #1;
        nVec++; if (enq_ready !== 1'b0) begin nErr++; $display("FAIL fullsc_enq_ready got %b exp 0", enq_ready); end
        nVec++; if (deq_pc !== 32'h1000) begin nErr++; $display("FAIL fullsc_head got %h exp 1000", deq_pc); end
        tick();
        idle();
        #1;
        nVec++; if (count !== 3'd3) begin nErr++; $display("FAIL fullsc_count got %0d exp 3", count); end
        nVec++; if (enq_ready !== 1'b1) begin nErr++; $display("FAIL fullsc_ready_after got %b exp 1", enq_ready); end
        for (int i = 1; i < 4; i++) begin
            deq_ready = 1'b1;
            #1;
            nVec++; if (deq_pc !== 32'h1000 + 32'(4 * i)) begin nErr++; $display("FAIL fullsc_drain got %h exp %h", deq_pc, 32'h1000 + 4 * i); end
            tick();
        end
        idle();
        #1;
        nVec++; if (deq_valid !== 1'b0) begin nErr++; $display("FAIL fullsc_refused_seen got %b exp 0", deq_valid); end
    endtask

    task automatic test_flush();
        idle();
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1; enq_pc = 32'h10 + 32'(4 * i); enq_instr = $urandom;
            tick();
        end
        flush = 1'b1; enq_valid = 1'b1; enq_pc = 32'h100; deq_ready = 1'($urandom);
        tick();
        idle();
        #1;
        nVec++; if (count !== 3'd0) begin nErr++; $display("FAIL flush_count got %0d exp 0", count); end
        nVec++; if (deq_valid !== 1'b0) begin nErr++; $display("FAIL flush_valid got %b exp 0", deq_valid); end
        nVec++; if (enq_ready !== 1'b1) begin nErr++; $display("FAIL flush_ready got %b exp 1", enq_ready); end
        enq_valid = 1'b1; enq_pc = 32'h200;
        tick();
        idle();
        #1;
        nVec++; if (deq_valid !== 1'b1 || deq_pc !== 32'h200) begin nErr++; $display("FAIL flush_next got %b/%h exp 1/200", deq_valid, deq_pc); end
        deq_ready = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_bypass();
        idle();
        enq_valid = 1'b1; enq_pc = 32'h40; enq_instr = 32'hABCD_0001; deq_ready = 1'b1;
        #1;
        if (BYP) begin
            nVec++; if (deq_valid !== 1'b1 || deq_pc !== 32'h40) begin nErr++; $display("FAIL bypass_same got %b/%h exp 1/40", deq_valid, deq_pc); end
            tick();
            idle();
            #1;
            nVec++; if (count !== 3'd0 || deq_valid !== 1'b0) begin nErr++; $display("FAIL bypass_after got %0d/%b exp 0/0", count, deq_valid); end
        end else begin
            nVec++; if (deq_valid !== 1'b0) begin nErr++; $display("FAIL nobypass_same got %b exp 0", deq_valid); end
            tick();
            enq_valid = 1'b0;
            #1;
            nVec++; if (deq_valid !== 1'b1 || deq_pc !== 32'h40 || count !== 3'd1) begin nErr++; $display("FAIL nobypass_next got %b/%h/%0d exp 1/40/1", deq_valid, deq_pc, count); end
            tick();
            idle();
        end
    endtask

    task automatic test_async_reset();
        idle();
        for (int i = 0; i < 2; i++) begin
            enq_valid = 1'b1; enq_pc = $urandom; tick();
        end
        idle();
        reset = 1'b0;
        #1;
        nVec++; if (count !== 3'd0 || deq_valid !== 1'b0) begin nErr++; $display("FAIL async_reset got %0d/%b exp 0/0", count, deq_valid); end
        q.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            enq_valid = 1'($urandom); deq_ready = 1'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            enq_pc = $urandom; enq_instr = $urandom;
            #1;
            nVec++; if (deq_valid !== expValid()) begin nErr++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, deq_valid, expValid()); end
            nVec++; if (deq_pc !== expPc()) begin nErr++; $display("FAIL rnd_pc c=%0d got %h exp %h", c, deq_pc, expPc()); end
            nVec++; if (deq_instr !== expInstr()) begin nErr++; $display("FAIL rnd_instr c=%0d got %h exp %h", c, deq_instr, expInstr()); end
            nVec++; if (count !== 3'(q.size())) begin nErr++; $display("FAIL rnd_count c=%0d got %0d exp %0d", c, count, q.size()); end
            nVec++; if (enq_ready !== (q.size() < DEPTH)) begin nErr++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, enq_ready, q.size() < DEPTH); end
            nVec++; if (almost_full !== (q.size() >= AFULL)) begin nErr++; $display("FAIL rnd_afull c=%0d got %b exp %b", c, almost_full, q.size() >= AFULL); end
            tick();
        end
        idle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_same_cycle();
        test_flush();
        test_bypass();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
